fetch_unit: RTL and testbench

Instruction fetch sequencer for the microcontroller. It drives the decoder's instruction-side interface (`IF`, `IR`, `instruction`) and is the producer for the decoder's consumer end. It owns the program counter, reads 16-bit instruction words from program memory over a req/ack handshake, and presents each word to the decoder. It waits for execution to complete, then applies any branch and fetches the next word.

---
 rtl/microcontroller_pkg.sv | 26 ++
 rtl/program_counter.sv | 36 +++
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/microcontroller_pkg.sv
// Shared definitions for the microcontroller: opcodes,
// instruction field widths and the fetch sequencer state encoding.
package microcontroller_pkg;

    localparam int OPC_W = 4;
    localparam int FLDA_W = 6;
    localparam int FLDB_W = 6;

    localparam logic [OPC_W-1:0] OP_ADDI = 4'd7;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_EXEC,
        ST_HALT
    } fetch_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(
        input logic [OPC_W+FLDA_W+FLDB_W-1:0] instr
    );
        return instr[OPC_W+FLDA_W+FLDB_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: load has priority over increment,
// and the increment wraps modulo 2^W.
module program_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] pc
);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        unique case (1'b1)
            load:    pc_d = load_val;
            inc:     pc_d = pc_q + W'(1);
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads words over req/ack, issues them
// to the decoder, waits for execution and applies branches.
module fetch_unit
    import microcontroller_pkg::*;
#(
    parameter int               PC_W    = 8,
    parameter int               INSTR_W = 16,
    parameter logic [OPC_W-1:0] HALT_OP = OP_HALT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               IF,
    output logic               IR,
    output logic [INSTR_W-1:0] instruction,
    input  logic               exec_done,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               halted
);

    fetch_state_e       state_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc;
    logic               pc_inc;
    logic               pc_load;
    logic               is_halt;

    assign pc_inc  = (state_q == ST_FETCH) && mem_ack;
    assign pc_load = (state_q == ST_EXEC) && exec_done && branch_taken;
    assign is_halt = instr_q[INSTR_W-1 -: OPC_W] == HALT_OP;

    program_counter #(
        .W(PC_W)
    ) u_pc (
        .clk     (clk),
        .reset   (reset),
        .inc     (pc_inc),
        .load    (pc_load),
        .load_val(branch_target),
        .pc      (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_q <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_ack) begin
                        instr_q <= mem_rdata;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state_q <= is_halt ? ST_HALT : ST_EXEC;
                ST_EXEC: begin
                    if (exec_done) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_req     = (state_q == ST_FETCH);
    assign IF          = (state_q == ST_FETCH);
    assign IR          = (state_q == ST_ISSUE);
    assign halted      = (state_q == ST_HALT);
    assign mem_addr    = pc;
    assign instruction = instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
// Inputs change 1ns after the rising edge; outputs are checked there.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        IF;
    logic        IR;
    logic [15:0] instruction;
    logic        exec_done;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        halted;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .IF           (IF),
        .IR           (IR),
        .instruction  (instruction),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halted       (halted)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait fetch from the current FETCH cycle, ending in EXEC.
    task automatic fetch_word(input logic [15:0] w, input logic [7:0] addr);
        check("fetch_addr", 32'(mem_addr), 32'(addr));
        check("fetch_req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        mem_rdata = w;
        tick();
        mem_ack = 1'b0;
        check("issue_ir", 32'(IR), 32'd1);
        check("issue_instr", 32'(instruction), 32'(w));
        tick();
    endtask

    task automatic finish_exec(input logic br, input logic [7:0] tgt);
        exec_done = 1'b1;
        branch_taken = br;
        branch_target = tgt;
        tick();
        exec_done = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        exec_done = 1'b0;
        branch_taken = 1'b0;
        branch_target = '0;
        #1;
        tick();
        tick();
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_if", 32'(IF), 32'd0);
        check("rst_ir", 32'(IR), 32'd0);
        check("rst_instr", 32'(instruction), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        reset = 1'b0;
        tick();
        check("first_if", 32'(IF), 32'd1);
        fetch_word(16'h700A, 8'h00);
        check("exec_ir_low", 32'(IR), 32'd0);
        finish_exec(1'b0, 8'h00);

        // Delayed ack; exec inputs asserted early must be ignored.
        exec_done = 1'b1;
        branch_taken = 1'b1;
        branch_target = 8'h99;
        for (int i = 0; i < 5; i++) begin
            check("wait_req", 32'(mem_req), 32'd1);
            check("wait_if", 32'(IF), 32'd1);
            check("wait_addr", 32'(mem_addr), 32'd1);
            check("wait_ir", 32'(IR), 32'd0);
            if (i < 4) tick();
        end
        exec_done = 1'b0;
        branch_taken = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0;
        check("late_ir", 32'(IR), 32'd1);
        check("late_instr", 32'(instruction), 32'h1234);
        exec_done = 1'b1;
        branch_taken = 1'b1;
        branch_target = 8'h55;
        tick();
        check("issue_ignores_done", 32'(mem_req), 32'd0);
        check("issue_ir_drop", 32'(IR), 32'd0);
        finish_exec(1'b1, 8'h40);
        check("branch_addr", 32'(mem_addr), 32'h40);
        check("branch_req", 32'(mem_req), 32'd1);

        fetch_word(16'h700A, 8'h40);
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        check("exec_ack_ign_req", 32'(mem_req), 32'd0);
        check("exec_ack_ign_ins", 32'(instruction), 32'h700A);
        finish_exec(1'b0, 8'h11);
        check("seq_addr", 32'(mem_addr), 32'h41);

        fetch_word(16'h700A, 8'h41);
        finish_exec(1'b1, 8'hFF);
        fetch_word(16'h700A, 8'hFF);
        finish_exec(1'b0, 8'h00);
        check("wrap_addr", 32'(mem_addr), 32'h00);

        fetch_word(16'hF000, 8'h00);
        for (int i = 0; i < 6; i++) begin
            mem_ack = 1'b1;
            exec_done = 1'b1;
            check("halt_flag", 32'(halted), 32'd1);
            check("halt_req", 32'(mem_req), 32'd0);
            check("halt_ir", 32'(IR), 32'd0);
            check("halt_instr", 32'(instruction), 32'hF000);
            check("halt_pc", 32'(mem_addr), 32'h01);
            tick();
        end
        mem_ack = 1'b0;
        exec_done = 1'b0;
        reset = 1'b1;
        tick();
        check("halt_rst_flag", 32'(halted), 32'd0);
        check("halt_rst_instr", 32'(instruction), 32'd0);
        reset = 1'b0;
        tick();
        check("restart_req", 32'(mem_req), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'd0);

        // Reset mid-FETCH with a colliding and then a late ack.
        fetch_word(16'h700A, 8'h00);
        finish_exec(1'b0, 8'h00);
        check("pre_rst_addr", 32'(mem_addr), 32'd1);
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 16'h5555;
        tick();
        check("midrst_instr", 32'(instruction), 32'd0);
        check("midrst_ir", 32'(IR), 32'd0);
        check("midrst_req", 32'(mem_req), 32'd0);
        reset = 1'b0;
        tick();
        mem_ack = 1'b0;
        check("lateack_instr", 32'(instruction), 32'd0);
        check("lateack_ir", 32'(IR), 32'd0);
        check("resume_addr", 32'(mem_addr), 32'd0);
        check("resume_req", 32'(mem_req), 32'd1);

        // Reset beats a simultaneous branch.
        fetch_word(16'h700A, 8'h00);
        reset = 1'b1;
        exec_done = 1'b1;
        branch_taken = 1'b1;
        branch_target = 8'h33;
        tick();
        reset = 1'b0;
        exec_done = 1'b0;
        branch_taken = 1'b0;
        check("rstwin_req", 32'(mem_req), 32'd0);
        tick();
        check("rstwin_addr", 32'(mem_addr), 32'd0);
        check("rstwin_fetch", 32'(mem_req), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
